// File: rtl/bc_pkg.sv
// Shared types and widths for the basic-computer registers.
// Used by the AR, PC and SC instances.
package bc_pkg;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_INC,
    CMD_DEC,
    CMD_CLR,
    CMD_CONFLICT
  } bc_cmd_t;

  localparam int ADDR_W = 12;
  localparam int BUS_W  = 16;

endpackage

// File: rtl/bc_cmd_decode.sv
// Maps the raw register strobes onto a single command.
// Any multi-strobe cycle decodes as a conflict.
module bc_cmd_decode
  import bc_pkg::*;
(
  input  logic    load,
  input  logic    inc,
  input  logic    dec,
  input  logic    clr,
  output bc_cmd_t cmd
);

  always_comb begin
    cmd = CMD_CONFLICT;
    case ({load, inc, dec, clr})
      4'b0000: cmd = CMD_NONE;
      4'b1000: cmd = CMD_LOAD;
      4'b0100: cmd = CMD_INC;
      4'b0010: cmd = CMD_DEC;
      4'b0001: cmd = CMD_CLR;
      default: cmd = CMD_CONFLICT;
    endcase
  end

endmodule

// File: rtl/bc_counter_reg.sv
// Address/program-counter register with wrap or saturate,
// carry pulse, zero flag and sticky command-conflict flag.
module bc_counter_reg
  import bc_pkg::*;
#(
  parameter int              WIDTH       = ADDR_W,
  parameter int              BUS_WIDTH   = BUS_W,
  parameter int              SATURATE    = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clr,
  input  logic                 err_ack,
  input  logic [BUS_WIDTH-1:0] indata,
  output logic [WIDTH-1:0]     outdata,
  output logic                 zero,
  output logic                 carry,
  output logic                 cmd_error
);

  localparam logic [WIDTH-1:0] ONES = '1;

  generate
    if (BUS_WIDTH < WIDTH) begin : g_bad_bus
      $error("bc_counter_reg: BUS_WIDTH must be >= WIDTH");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("bc_counter_reg: WIDTH must be in 2..32");
    end
    if (BUS_WIDTH > WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^indata[BUS_WIDTH-1:WIDTH];
    end
  endgenerate

  bc_cmd_t          cmd;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_nxt;
  logic             carry_nxt;

  bc_cmd_decode u_decode (
    .load (load),
    .inc  (inc),
    .dec  (dec),
    .clr  (clr),
    .cmd  (cmd)
  );

  always_comb begin
    data_nxt  = data;
    carry_nxt = 1'b0;
    case (cmd)
      CMD_LOAD: data_nxt = indata[WIDTH-1:0];
      CMD_INC: begin
        if (data == ONES) begin
          carry_nxt = 1'b1;
          data_nxt  = (SATURATE != 0) ? ONES : '0;
        end else begin
          data_nxt = data + WIDTH'(1);
        end
      end
      CMD_DEC: begin
        if (data == '0) begin
          carry_nxt = 1'b1;
          data_nxt  = (SATURATE != 0) ? '0 : ONES;
        end else begin
          data_nxt = data - WIDTH'(1);
        end
      end
      CMD_CLR: data_nxt = RESET_VALUE;
      default: data_nxt = data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= RESET_VALUE;
      carry <= 1'b0;
    end else begin
      data  <= data_nxt;
      carry <= carry_nxt;
    end
  end

  // Set beats acknowledge so a conflict is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_error <= 1'b0;
    end else if (cmd == CMD_CONFLICT) begin
      cmd_error <= 1'b1;
    end else if (err_ack) begin
      cmd_error <= 1'b0;
    end
  end

  assign outdata = data;
  assign zero    = (data == '0);

endmodule
